ik_swift_host_bridge: RTL and testbench
=======================================

# ik_swift_host_bridge

Memory-mapped host-side initiator for the IK solver. It sits between the HPS bus slave port and the `ifc_ik_swift` solver interface. It packs 32-bit host writes into the 27-bit solver operand fields and sequences solver reset/enable for a fixed run length. It then captures the six joint deltas and returns them to the host with a done flag and interrupt.

## Interface
- `LATENCY`, default 64: solver cycles with `sol_en` high per run (≥1).
- `FW`, default 27: fixed-point field width.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `chipselect`  in  1  bus select.
- `write`  in  1  write strobe (qualified by `chipselect`).
- `read`  in  1  read strobe (qualified by `chipselect`).
- `address`  in  6  word address.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data, registered.
- `irq`  out  1  `done & irq_en`.
- `sol_rst`  out  1  solver synchronous clear.
- `sol_en`  out  1  solver enable.
- `sol_z`  out  3×FW  base axis.
- `sol_joint_type`  out  6  joint type bits.
- `sol_dh_param`  out  6×4×FW  DH parameters, `[joint][param]`.
- `sol_target`  out  6×FW  target pose.
- `sol_delta`  in  6×FW  solver delta output.

## Operation
- Address map (word):
  - 0–2 `z[0..2]`.
  - 3 `joint_type` (bits 5:0).
  - 4–27 `dh_param`, address = 4 + 4·joint + param.
  - 28–33 `target[0..5]`.
  - 34 CTRL: bit0 START (write-only, self-clearing); bit1 IRQ_EN (R/W).
  - 35 STATUS: bit0 BUSY, bit1 DONE, bit2 ERR. Writing 1 to DONE or ERR clears that bit.
  - 36–41 `delta[0..5]`, read-only.
  - Other addresses: reads return 0, writes are ignored.
- Operand writes store `writedata[FW-1:0]`; the upper bits are discarded.
- Operand reads return the stored field sign-extended to 32 bits. Delta reads are sign-extended the same way.
- FSM states:
  - IDLE: `sol_rst=0`, `sol_en=0`.
  - A START write moves IDLE to CLEAR. On that edge, DONE clears and BUSY sets.
  - CLEAR lasts 1 cycle with `sol_rst=1`, then goes to RUN and loads the counter with LATENCY-1.
  - RUN holds `sol_en=1` and decrements the counter. When the counter reaches 0, the state goes to CAPTURE.
  - CAPTURE latches `sol_delta` into the delta registers, sets DONE, clears BUSY, and returns to IDLE.
- While BUSY, operand and START writes are dropped and ERR is set. CTRL.IRQ_EN and STATUS W1C writes are still accepted. Operand registers never change during a run.
- Same-cycle START and DONE-clear write: impossible, because they are separate addresses.
- If a W1C of DONE arrives on the same edge CAPTURE sets DONE, the set wins.
- Delta registers hold the previous run's values until CAPTURE.
- Reset values:
  - All operand and delta registers 0, IRQ_EN 0, STATUS 0.
  - `readdata` 0, `irq` 0, `sol_en` 0.
  - `sol_rst` 1 while `rst` is high. It first deasserts on the first clock edge after reset release.
  - FSM returns to IDLE.
- Reset mid-run aborts immediately and does not set DONE.

## Timing
- Reads have 1-cycle latency: `readdata` is valid the cycle after the `read` strobe.
- Writes take effect on the sampling edge. Operand outputs are register-driven and change the cycle after the write.
- With START sampled at edge N:
  - CLEAR occupies cycle N+1.
  - `sol_en` is high for cycles N+2 … N+1+LATENCY.
  - CAPTURE is cycle N+2+LATENCY.
  - DONE and `irq` are visible from N+3+LATENCY.
  - Start to done is LATENCY+2 cycles.
- No combinational path from bus inputs to any solver output.

## Structure
- Package `ik_swift_pkg` holds:
  - `FW`;
  - typedefs `fixed_t` (`logic [FW-1:0]`), `vec3_t`, `vec6_t`, `dh_t` (`[5:0][3:0]` of `fixed_t`);
  - address constants `ADDR_Z`, `ADDR_JT`, `ADDR_DH`, `ADDR_TGT`, `ADDR_CTRL`, `ADDR_STAT`, `ADDR_DELTA`;
  - the FSM state enum.
- One sub-module, `ik_swift_run_seq`: the FSM plus counter. Inputs are `start` and `busy`; outputs are `sol_rst`, `sol_en`, `capture`, `busy`.
- Register file and read mux are in the top level.
- Connects to the solver through the `ifc_ik_swift` interface at the integration level.

## Test plan
- Reset: hold `rst` for 3 cycles → all outputs at reset values, `sol_rst=1`. After release, `sol_rst=0` from the first edge, and STATUS reads 0.
- Operand round-trip:
  - Write 0xFFFF_FFFF to addr 4 → reads back 0xFFFF_FFFF (sign-extended).
  - Write 0x0000_1234 to addr 28 → `sol_target[0]=27'h1234`, reads back 0x1234.
- Run with LATENCY=4 and a stub solver driving `sol_delta[k]=k+1`: START at edge N →
  - `sol_rst` high in cycle N+1 only;
  - `sol_en` high in cycles N+2..N+5;
  - DONE=1 at N+7;
  - addrs 36–41 read 1..6.
- Busy protection: write addr 0 and START during RUN → `sol_z` unchanged, no restart, ERR=1. W1C of 0x4 to STATUS → ERR=0.
- IRQ:
  - IRQ_EN=1, run completes → `irq=1`.
  - Write 0x2 to STATUS → `irq=0`.
  - IRQ_EN=0 run → `irq` stays 0 while DONE=1.
- Reset mid-RUN → `sol_en` drops asynchronously, BUSY=0, DONE=0, deltas 0. A new START then runs normally.

Source files
------------

// File: rtl/ik_swift_pkg.sv
// Shared types, register map and sequencer states for the IK solver host bridge.
package ik_swift_pkg;

  localparam int FW = 27;

  typedef logic [FW-1:0]     fixed_t;
  typedef fixed_t [2:0]      vec3_t;
  typedef fixed_t [5:0]      vec6_t;
  typedef fixed_t [5:0][3:0] dh_t;

  // Word addresses of the host-visible register map
  localparam logic [5:0] ADDR_Z     = 6'd0;
  localparam logic [5:0] ADDR_JT    = 6'd3;
  localparam logic [5:0] ADDR_DH    = 6'd4;
  localparam logic [5:0] ADDR_TGT   = 6'd28;
  localparam logic [5:0] ADDR_CTRL  = 6'd34;
  localparam logic [5:0] ADDR_STAT  = 6'd35;
  localparam logic [5:0] ADDR_DELTA = 6'd36;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } run_state_e;

endpackage

// File: rtl/ik_swift_run_seq.sv
// Solver run sequencer: one clear cycle, LATENCY enable cycles, one capture cycle.
module ik_swift_run_seq
  import ik_swift_pkg::*;
#(
  parameter int LATENCY = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic busy_i,
  output logic sol_rst_o,
  output logic sol_en_o,
  output logic capture_o,
  output logic busy_o
);

  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  run_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sol_rst_q, sol_en_q;

  // Next-state and run-length counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !busy_i) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_d = ST_RUN;
        cnt_d   = CNT_LOAD;
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered solver controls; solver is held in clear during reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sol_rst_q <= 1'b1;
      sol_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sol_rst_q <= (state_d == ST_CLEAR);
      sol_en_q  <= (state_d == ST_RUN);
    end
  end

  assign sol_rst_o = sol_rst_q;
  assign sol_en_o  = sol_en_q;
  assign capture_o = (state_q == ST_CAPTURE);
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: rtl/ik_swift_host_bridge.sv
// Host bus register file that loads IK solver operands, runs the solver and returns deltas.
module ik_swift_host_bridge #(
  parameter int LATENCY = 64,
  parameter int FW      = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    chipselect,
  input  logic                    write,
  input  logic                    read,
  input  logic [5:0]              address,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic                    irq,
  output logic                    sol_rst,
  output logic                    sol_en,
  output logic [2:0][FW-1:0]      sol_z,
  output logic [5:0]              sol_joint_type,
  output logic [5:0][3:0][FW-1:0] sol_dh_param,
  output logic [5:0][FW-1:0]      sol_target,
  input  logic [5:0][FW-1:0]      sol_delta
);
  import ik_swift_pkg::*;

  function automatic logic [31:0] sext(input logic [FW-1:0] v);
    return {{(32-FW){v[FW-1]}}, v};
  endfunction

  logic [2:0][FW-1:0]      z_q;
  logic [5:0]              jt_q;
  logic [5:0][3:0][FW-1:0] dh_q;
  logic [5:0][FW-1:0]      tgt_q;
  logic [5:0][FW-1:0]      delta_q;
  logic                    irq_en_q, busy_q, done_q, err_q;
  logic [31:0]             readdata_q;
  logic [31:0]             rdata_s;

  logic       wr_s, rd_s;
  logic       is_z_s, is_jt_s, is_dh_s, is_tgt_s, is_operand_s, is_delta_s;
  logic       ctrl_wr_s, stat_wr_s, start_wr_s, start_ok_s;
  logic       blocked_s, op_wr_s, err_set_s;
  logic [1:0] z_idx_s;
  logic [4:0] dh_off_s;
  logic [2:0] tgt_off_s, dl_off_s;
  logic       seq_busy_s, capture_s;
  logic       wd_unused_s;

  assign wr_s = chipselect & write;
  assign rd_s = chipselect & read;

  assign is_z_s       = (address < ADDR_JT);
  assign is_jt_s      = (address == ADDR_JT);
  assign is_dh_s      = (address >= ADDR_DH) && (address < ADDR_TGT);
  assign is_tgt_s     = (address >= ADDR_TGT) && (address < ADDR_CTRL);
  assign is_operand_s = (address < ADDR_CTRL);
  assign is_delta_s   = (address >= ADDR_DELTA) && (address < (ADDR_DELTA + 6'd6));

  assign z_idx_s   = 2'(address - ADDR_Z);
  assign dh_off_s  = 5'(address - ADDR_DH);
  assign tgt_off_s = 3'(address - ADDR_TGT);
  assign dl_off_s  = 3'(address - ADDR_DELTA);

  assign ctrl_wr_s  = wr_s & (address == ADDR_CTRL);
  assign stat_wr_s  = wr_s & (address == ADDR_STAT);
  assign start_wr_s = ctrl_wr_s & writedata[0];

  // Operand and START writes are refused for the whole run, including the clear cycle
  assign blocked_s  = busy_q | seq_busy_s;
  assign start_ok_s = start_wr_s & ~blocked_s;
  assign op_wr_s    = wr_s & is_operand_s & ~blocked_s;
  assign err_set_s  = blocked_s & ((wr_s & is_operand_s) | start_wr_s);

  // Upper write-data bits have no home in the narrower operand fields
  assign wd_unused_s = ^writedata[31:FW];

  ik_swift_run_seq #(
    .LATENCY (LATENCY)
  ) u_run_seq (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_wr_s),
    .busy_i    (busy_q),
    .sol_rst_o (sol_rst),
    .sol_en_o  (sol_en),
    .capture_o (capture_s),
    .busy_o    (seq_busy_s)
  );

  // Operand register file, frozen while a run is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q   <= '0;
      jt_q  <= 6'd0;
      dh_q  <= '0;
      tgt_q <= '0;
    end else if (op_wr_s) begin
      if (is_z_s) begin
        z_q[z_idx_s] <= writedata[FW-1:0];
      end else if (is_jt_s) begin
        jt_q <= writedata[5:0];
      end else if (is_dh_s) begin
        dh_q[dh_off_s[4:2]][dh_off_s[1:0]] <= writedata[FW-1:0];
      end else if (is_tgt_s) begin
        tgt_q[tgt_off_s] <= writedata[FW-1:0];
      end
    end
  end

  // Control and status bits; a DONE set on capture beats a same-edge W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (ctrl_wr_s) begin
        irq_en_q <= writedata[1];
      end

      if (start_ok_s) begin
        busy_q <= 1'b1;
      end else if (capture_s) begin
        busy_q <= 1'b0;
      end

      if (capture_s) begin
        done_q <= 1'b1;
      end else if (stat_wr_s && writedata[1]) begin
        done_q <= 1'b0;
      end else if (start_ok_s) begin
        done_q <= 1'b0;
      end

      if (err_set_s) begin
        err_q <= 1'b1;
      end else if (stat_wr_s && writedata[2]) begin
        err_q <= 1'b0;
      end
    end
  end

  // Delta capture; previous results stay visible until the next run completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delta_q <= '0;
    end else if (capture_s) begin
      delta_q <= sol_delta;
    end
  end

  // Read mux over the register map; unmapped words read as zero
  always_comb begin
    rdata_s = 32'd0;
    if (is_z_s) begin
      rdata_s = sext(z_q[z_idx_s]);
    end else if (is_jt_s) begin
      rdata_s = {26'd0, jt_q};
    end else if (is_dh_s) begin
      rdata_s = sext(dh_q[dh_off_s[4:2]][dh_off_s[1:0]]);
    end else if (is_tgt_s) begin
      rdata_s = sext(tgt_q[tgt_off_s]);
    end else if (address == ADDR_CTRL) begin
      rdata_s = {30'd0, irq_en_q, 1'b0};
    end else if (address == ADDR_STAT) begin
      rdata_s = {29'd0, err_q, done_q, busy_q};
    end else if (is_delta_s) begin
      rdata_s = sext(delta_q[dl_off_s]);
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Registered read data, updated only on a qualified read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata_q <= 32'd0;
    end else if (rd_s) begin
      readdata_q <= rdata_s;
    end
  end

  assign readdata       = readdata_q;
  assign irq            = done_q & irq_en_q;
  assign sol_z          = z_q;
  assign sol_joint_type = jt_q;
  assign sol_dh_param   = dh_q;
  assign sol_target     = tgt_q;

endmodule

// File: tb/tb_ik_swift_host_bridge.sv
// Randomized self-checking bench for ik_swift_host_bridge against a register-map model.
module tb_ik_swift_host_bridge;

  localparam int L = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   chipselect, write, read;
  logic [5:0]             address;
  logic [31:0]            writedata;
  logic [31:0]            readdata;
  logic                   irq, sol_rst, sol_en;
  logic [2:0][26:0]       sol_z;
  logic [5:0]             sol_joint_type;
  logic [5:0][3:0][26:0]  sol_dh_param;
  logic [5:0][26:0]       sol_target;
  logic [5:0][26:0]       stub_delta;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the register map
  logic [26:0] m_z [3];
  logic [5:0]  m_jt;
  logic [26:0] m_dh [24];
  logic [26:0] m_tgt [6];
  logic [26:0] m_delta [6];
  logic        m_irq_en, m_done, m_err;

  always #5 clk = ~clk;

  ik_swift_host_bridge #(.LATENCY(L), .FW(27)) dut (
    .clk            (clk),
    .rst            (rst),
    .chipselect     (chipselect),
    .write          (write),
    .read           (read),
    .address        (address),
    .writedata      (writedata),
    .readdata       (readdata),
    .irq            (irq),
    .sol_rst        (sol_rst),
    .sol_en         (sol_en),
    .sol_z          (sol_z),
    .sol_joint_type (sol_joint_type),
    .sol_dh_param   (sol_dh_param),
    .sol_target     (sol_target),
    .sol_delta      (stub_delta)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [26:0] v);
    return {{5{v[26]}}, v};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_z[i] = '0;
    for (int i = 0; i < 24; i++) m_dh[i] = '0;
    for (int i = 0; i < 6; i++) begin
      m_tgt[i] = '0;
      m_delta[i] = '0;
    end
    m_jt = '0; m_irq_en = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endfunction

  // Idle-state write semantics
  function automatic void model_write(input int a, input logic [31:0] d);
    if (a < 3) m_z[a] = d[26:0];
    else if (a == 3) m_jt = d[5:0];
    else if (a < 28) m_dh[a-4] = d[26:0];
    else if (a < 34) m_tgt[a-28] = d[26:0];
    else if (a == 34) m_irq_en = d[1];
    else if (a == 35) begin
      if (d[1]) m_done = 1'b0;
      if (d[2]) m_err = 1'b0;
    end
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a < 3) return sx(m_z[a]);
    else if (a == 3) return {26'd0, m_jt};
    else if (a < 28) return sx(m_dh[a-4]);
    else if (a < 34) return sx(m_tgt[a-28]);
    else if (a == 34) return {30'd0, m_irq_en, 1'b0};
    else if (a == 35) return {29'd0, m_err, m_done, 1'b0};
    else if (a < 42) return sx(m_delta[a-36]);
    return 32'd0;
  endfunction

  task automatic bus_drive_wr(input int a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = 6'(a); writedata = d;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 6'd0; writedata = 32'd0;
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    @(negedge clk);
    bus_drive_wr(a, d);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 6'(a);
    @(negedge clk);
    bus_idle();
    d = readdata;
  endtask

  task automatic read_check(input string tag, input int a);
    logic [31:0] d;
    bus_read(a, d);
    check_val(tag, d, model_read(a));
  endtask

  task automatic check_operands();
    for (int i = 0; i < 3; i++) check_val("sol_z", 32'(sol_z[i]), 32'(m_z[i]));
    check_val("sol_jt", 32'(sol_joint_type), 32'(m_jt));
    for (int i = 0; i < 24; i++) check_val("sol_dh", 32'(sol_dh_param[i/4][i%4]), 32'(m_dh[i]));
    for (int i = 0; i < 6; i++) check_val("sol_tgt", 32'(sol_target[i]), 32'(m_tgt[i]));
  endtask

  // One run, checked cycle by cycle relative to the START edge; optional busy-time traffic
  task automatic run_and_check(input bit inject);
    logic [31:0] zdat;
    zdat = $urandom;
    @(negedge clk);
    bus_drive_wr(34, {30'd0, m_irq_en, 1'b1});
    for (int k = 1; k <= L + 3; k++) begin
      @(negedge clk);
      check_val($sformatf("sol_rst_c%0d", k), 32'(sol_rst), 32'(k == 1));
      check_val($sformatf("sol_en_c%0d", k), 32'(sol_en), 32'(k >= 2 && k <= L + 1));
      check_val($sformatf("irq_c%0d", k), 32'(irq), 32'((k >= L + 3) && m_irq_en));
      if (inject && k == 2) bus_drive_wr(0, zdat);
      else if (inject && k == 3) bus_drive_wr(34, {30'd0, m_irq_en, 1'b1});
      else bus_idle();
    end
    for (int i = 0; i < 6; i++) m_delta[i] = stub_delta[i];
    m_done = 1'b1;
    if (inject) m_err = 1'b1;
    check_operands();
    read_check("status_after_run", 35);
    for (int i = 0; i < 6; i++) read_check($sformatf("delta%0d", i), 36 + i);
  endtask

  initial begin
    logic [31:0] d;
    int a;
    rst = 1'b1;
    bus_idle();
    for (int i = 0; i < 6; i++) stub_delta[i] = 27'(i + 1);
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_sol_rst", 32'(sol_rst), 32'd1);
    check_val("rst_sol_en", 32'(sol_en), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_readdata", readdata, 32'd0);
    check_operands();
    rst = 1'b0;
    @(negedge clk);
    check_val("rel_sol_rst", 32'(sol_rst), 32'd0);
    read_check("rst_status", 35);

    // Operand round-trip with sign extension
    bus_write(4, 32'hFFFF_FFFF);
    model_write(4, 32'hFFFF_FFFF);
    bus_read(4, d);
    check_val("rt_dh_sext", d, 32'hFFFF_FFFF);
    bus_write(28, 32'h0000_1234);
    model_write(28, 32'h0000_1234);
    check_val("rt_tgt_out", 32'(sol_target[0]), 32'h0000_1234);
    bus_read(28, d);
    check_val("rt_tgt_rd", d, 32'h0000_1234);

    // Random register traffic while idle
    for (int n = 0; n < 120; n++) begin
      a = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        if (a == 34) d[0] = 1'b0;
        bus_write(a, d);
        model_write(a, d);
      end else begin
        read_check($sformatf("rand_rd_a%0d", a), a);
      end
      check_val("rand_irq", 32'(irq), 32'(m_done & m_irq_en));
    end
    check_operands();

    // Run with IRQ enabled and the k+1 stub, then clear DONE
    bus_write(34, 32'h2);
    model_write(34, 32'h2);
    run_and_check(1'b0);
    check_val("irq_set", 32'(irq), 32'd1);
    bus_write(35, 32'h2);
    model_write(35, 32'h2);
    @(negedge clk);
    check_val("irq_clr", 32'(irq), 32'd0);

    // Busy protection: operand and START writes during RUN are refused and flag ERR
    for (int i = 0; i < 6; i++) stub_delta[i] = 27'($urandom);
    bus_write(1, 32'h0ABC_DEF0);
    model_write(1, 32'h0ABC_DEF0);
    run_and_check(1'b1);
    bus_write(35, 32'h4);
    model_write(35, 32'h4);
    read_check("err_clr", 35);

    // IRQ disabled: DONE sets but irq stays low
    bus_write(34, 32'h0);
    model_write(34, 32'h0);
    for (int i = 0; i < 6; i++) stub_delta[i] = 27'($urandom);
    run_and_check(1'b0);
    check_val("irq_dis", 32'(irq), 32'd0);

    // Reset in the middle of RUN, then a clean run
    @(negedge clk);
    bus_drive_wr(34, 32'h1);
    repeat (3) @(negedge clk) bus_idle();
    check_val("mid_sol_en_pre", 32'(sol_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("mid_sol_en_async", 32'(sol_en), 32'd0);
    check_val("mid_sol_rst", 32'(sol_rst), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    read_check("mid_status", 35);
    for (int i = 0; i < 6; i++) read_check($sformatf("mid_delta%0d", i), 36 + i);
    for (int i = 0; i < 6; i++) stub_delta[i] = 27'($urandom);
    run_and_check(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
